// File: rtl/irq_sched.sv
// irq_sched: interrupt scheduler between NSRC hardware interrupt lines and
// the single CP0 exception entry. Raw lines are synchronised, rising edges
// are latched as pending requests, masked by a software enable register,
// arbitrated, and each grant is walked through request / acknowledge /
// done, with a watchdog that recovers from a lost rfe.
//
// Build option: define IRQ_SCHED_RR_EN for round-robin arbitration
// (search starts after the most recently acknowledged id). Without it the
// lowest pending index always wins.

module irq_sched #(
    parameter int NSRC    = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] hwint,
    input  logic            en_we,
    input  logic [NSRC-1:0] en_wd,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            irq,
    output logic [IDW-1:0]  irq_id,
    output logic [31:0]     cause,
    output logic [NSRC-1:0] pending,
    output logic            busy,
    output logic            tmo_err
);

    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_sync2_d;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_enable;
    logic            r_irq;
    logic [IDW-1:0]  r_irq_id;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic            r_tmo_err;
`ifdef IRQ_SCHED_RR_EN
    logic [IDW-1:0]  r_last_id;
`endif

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_cand;
    logic [NSRC-1:0] w_clr;
    logic [IDW-1:0]  w_start;
    logic [IDW-1:0]  w_win;

    // Pick the first set bit of cand, searching upward from start and
    // wrapping. Scanning downward lets the lowest rotated offset win.
    function automatic logic [IDW-1:0] f_pick(input logic [NSRC-1:0] cand,
                                              input logic [IDW-1:0]  start);
        logic [NSRC-1:0] rot;
        logic [IDW-1:0]  pick;
        rot  = NSRC'({cand, cand} >> start);
        pick = start;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = IDW'((int'(start) + k) % NSRC);
            end
        end
        return pick;
    endfunction

    assign w_rise = r_sync2 & ~r_sync2_d;
    assign w_cand = r_pending & r_enable;
    assign w_win  = f_pick(w_cand, w_start);

    // Arbitration start point: after the last acknowledged id, or index 0.
    always_comb begin
        w_start = IDW'(0);
`ifdef IRQ_SCHED_RR_EN
        if (int'(r_last_id) == NSRC - 1) begin
            w_start = IDW'(0);
        end else begin
            w_start = r_last_id + IDW'(1);
        end
`endif
    end

    // One-hot clear of the granted source's pending bit on acknowledge.
    always_comb begin
        w_clr = NSRC'(0);
        if (r_state == ST_REQ && int_ack) begin
            w_clr = NSRC'(1) << r_irq_id;
        end else begin
            w_clr = NSRC'(0);
        end
    end

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= NSRC'(0);
            r_sync2   <= NSRC'(0);
            r_sync2_d <= NSRC'(0);
        end else begin
            r_sync1   <= hwint;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    // Software enable register; all sources enabled out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable <= {NSRC{1'b1}};
        end else if (en_we) begin
            r_enable <= en_wd;
        end
    end

    // Pending latch: a new edge wins over a simultaneous acknowledge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= NSRC'(0);
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Service sequencer: grant, wait for ack, then wait for done or timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_irq_id  <= IDW'(0);
            r_busy    <= 1'b0;
            r_cnt     <= CW'(0);
            r_tmo_err <= 1'b0;
`ifdef IRQ_SCHED_RR_EN
            r_last_id <= IDW'(0);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_irq_id <= w_win;
                        r_irq    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_irq   <= 1'b0;
                        r_cnt   <= CW'(0);
                        r_state <= ST_SERVICE;
`ifdef IRQ_SCHED_RR_EN
                        r_last_id <= r_irq_id;
`endif
                    end
                end
                ST_SERVICE: begin
                    if (int_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CW'(TMO_CYC - 1)) begin
                        r_tmo_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq     = r_irq;
    assign irq_id  = r_irq_id;
    assign pending = r_pending;
    assign busy    = r_busy;
    assign tmo_err = r_tmo_err;
    assign cause   = {16'h0000, 8'(r_pending), 3'b000, r_tmo_err, 2'b00, 2'(r_irq_id)};

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched (NSRC=4, TMO_CYC=8). Expected grant ids
// are queued when edges are driven and compared when irq rises.

module tb_irq_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  hwint;
    logic        en_we;
    logic [3:0]  en_wd;
    logic        int_ack;
    logic        int_done;
    logic        irq;
    logic [1:0]  irq_id;
    logic [31:0] cause;
    logic [3:0]  pending;
    logic        busy;
    logic        tmo_err;

    int          n_pass;
    int          n_total;
    logic [1:0]  exp_q[$];
    logic [1:0]  exp_id;
    logic        ok;

    irq_sched #(.NSRC(4), .IDW(2), .TMO_CYC(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .hwint    (hwint),
        .en_we    (en_we),
        .en_wd    (en_wd),
        .int_ack  (int_ack),
        .int_done (int_done),
        .irq      (irq),
        .irq_id   (irq_id),
        .cause    (cause),
        .pending  (pending),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; hwint = 4'b0000; en_we = 1'b0; en_wd = 4'b0000;
        int_ack = 1'b0; int_done = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic wait_irq(output logic got);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!got) begin
                if (irq === 1'b1) got = 1'b1;
                else step();
            end
        end
    endtask

    task automatic pop_exp();
        if (exp_q.size() > 0) exp_id = exp_q.pop_front();
        else exp_id = 2'bxx;
    endtask

    task automatic ack_done();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        step();
        int_done = 1'b1; step(); int_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
        n_total++; if (irq_id !== 2'd0) $display("FAIL rst_id: got %0d want 0", irq_id); else n_pass++;
        n_total++; if (pending !== 4'b0000) $display("FAIL rst_pend: got %b want 0000", pending); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (tmo_err !== 1'b0) $display("FAIL rst_tmo: got %b want 0", tmo_err); else n_pass++;
        n_total++; if (cause !== 32'h0) $display("FAIL rst_cause: got %h want 0", cause); else n_pass++;
    endtask

    task automatic test_single();
        hwint = 4'b0100; exp_q.push_back(2'd2);
        step();                        // edge k: first sample
        step();                        // k+1
        n_total++; if (pending !== 4'b0000) $display("FAIL lat_pend_k1: got %b want 0000", pending); else n_pass++;
        step();                        // k+2
        n_total++; if (pending !== 4'b0100 || irq !== 1'b0)
            $display("FAIL lat_pend_k2: got pend=%b irq=%b want pend=0100 irq=0", pending, irq); else n_pass++;
        step();                        // k+3
        pop_exp();
        n_total++; if (irq !== 1'b1 || irq_id !== exp_id)
            $display("FAIL lat_irq_k3: got irq=%b id=%0d want irq=1 id=%0d", irq, irq_id, exp_id); else n_pass++;
        hwint = 4'b0000;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_total++; if (irq !== 1'b0 || pending !== 4'b0000 || busy !== 1'b1)
            $display("FAIL single_ack: got irq=%b pend=%b busy=%b want 0 0000 1", irq, pending, busy); else n_pass++;
        n_total++; if (cause !== 32'h0000_0002) $display("FAIL single_cause: got %h want 00000002", cause); else n_pass++;
        int_done = 1'b1; step(); int_done = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL single_done: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        hwint = 4'b1010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL prio_first: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        hwint = 4'b0000;
        ack_done();
        n_total++; if (irq !== 1'b0) $display("FAIL prio_gap: got irq=%b want 0", irq); else n_pass++;
        step(); pop_exp();
        n_total++; if (irq !== 1'b1 || irq_id !== exp_id)
            $display("FAIL prio_regrant: got irq=%b id=%0d want irq=1 id=%0d", irq, irq_id, exp_id); else n_pass++;
        ack_done();
    endtask

    task automatic test_rr_order();
        hwint = 4'b0010; exp_q.push_back(2'd1);
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL arb_setup: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        hwint = 4'b0000;
        ack_done();
        step(); step(); step();
        hwint = 4'b1001;
`ifdef IRQ_SCHED_RR_EN
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
`else
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
`endif
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL arb_first: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        hwint = 4'b0000;
        ack_done();
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL arb_second: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        ack_done();
    endtask

    task automatic test_mask();
        en_we = 1'b1; en_wd = 4'b1110; step(); en_we = 1'b0;
        hwint = 4'b0001; exp_q.push_back(2'd0);
        for (int c = 0; c < 6; c++) step();
        hwint = 4'b0000;
        n_total++; if (pending !== 4'b0001 || irq !== 1'b0)
            $display("FAIL mask_hold: got pend=%b irq=%b want 0001 0", pending, irq); else n_pass++;
        en_we = 1'b1; en_wd = 4'b1111; step(); en_we = 1'b0;
        n_total++; if (irq !== 1'b0) $display("FAIL mask_early: got irq=%b want 0", irq); else n_pass++;
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL mask_grant: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        ack_done();
    endtask

    task automatic test_collision();
        hwint = 4'b0100; exp_q.push_back(2'd2);
        wait_irq(ok); pop_exp();
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL coll_grant: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        hwint = 4'b0000;
        step(); step(); step(); step();
        n_total++; if (irq !== 1'b1 || irq_id !== 2'd2)
            $display("FAIL coll_hold: got irq=%b id=%0d want 1 2", irq, irq_id); else n_pass++;
        hwint = 4'b0100;
        step(); step();                // rise now visible; ack lands with it
        int_ack = 1'b1; exp_q.push_back(2'd2); step(); int_ack = 1'b0;
        hwint = 4'b0000;
        n_total++; if (pending !== 4'b0100 || irq !== 1'b0 || busy !== 1'b1)
            $display("FAIL coll_setwins: got pend=%b irq=%b busy=%b want 0100 0 1", pending, irq, busy); else n_pass++;
        int_done = 1'b1; step(); int_done = 1'b0;
        step(); pop_exp();
        n_total++; if (irq !== 1'b1 || irq_id !== exp_id)
            $display("FAIL coll_regrant: got irq=%b id=%0d want irq=1 id=%0d", irq, irq_id, exp_id); else n_pass++;
        ack_done();
    endtask

    task automatic test_watchdog();
        // done arriving on the final watchdog cycle takes precedence
        hwint = 4'b0010; exp_q.push_back(2'd1);
        wait_irq(ok); pop_exp(); hwint = 4'b0000;
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL wd_grant1: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        for (int c = 0; c < 7; c++) step();
        int_done = 1'b1; step(); int_done = 1'b0;
        n_total++; if (tmo_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL wd_donewins: got tmo=%b busy=%b want 0 0", tmo_err, busy); else n_pass++;
        // no done: watchdog expires after 8 SERVICE cycles
        hwint = 4'b0100; exp_q.push_back(2'd2);
        wait_irq(ok); pop_exp(); hwint = 4'b0000;
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL wd_grant2: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        for (int c = 0; c < 7; c++) step();
        n_total++; if (tmo_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL wd_early: got tmo=%b busy=%b want 0 1", tmo_err, busy); else n_pass++;
        step();
        n_total++; if (tmo_err !== 1'b1 || busy !== 1'b0 || cause[4] !== 1'b1)
            $display("FAIL wd_expire: got tmo=%b busy=%b cause4=%b want 1 0 1", tmo_err, busy, cause[4]); else n_pass++;
        hwint = 4'b1000; exp_q.push_back(2'd3);
        wait_irq(ok); pop_exp(); hwint = 4'b0000;
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL wd_after: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        ack_done();
        n_total++; if (tmo_err !== 1'b1) $display("FAIL wd_sticky: got tmo=%b want 1", tmo_err); else n_pass++;
    endtask

    task automatic test_async_reset();
        hwint = 4'b0001; exp_q.push_back(2'd0);
        wait_irq(ok); pop_exp(); hwint = 4'b0000;
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL ar_grant: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        hwint = 4'b0100;
        step(); step(); step();
        hwint = 4'b0000;
        n_total++; if (pending !== 4'b0100 || busy !== 1'b1)
            $display("FAIL ar_pre: got pend=%b busy=%b want 0100 1", pending, busy); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (irq !== 1'b0 || busy !== 1'b0 || pending !== 4'b0000)
            $display("FAIL ar_async: got irq=%b busy=%b pend=%b want 0 0 0000", irq, busy, pending); else n_pass++;
        n_total++; if (tmo_err !== 1'b0 || cause !== 32'h0)
            $display("FAIL ar_tmo: got tmo=%b cause=%h want 0 0", tmo_err, cause); else n_pass++;
        #2 reset = 1'b1;
        step();
        // enable must be back to all ones: line 3 is granted without any write
        hwint = 4'b1000; exp_q.push_back(2'd3);
        wait_irq(ok); pop_exp(); hwint = 4'b0000;
        n_total++; if (!ok || irq_id !== exp_id) $display("FAIL ar_enable: got ok=%b id=%0d want id=%0d", ok, irq_id, exp_id); else n_pass++;
        ack_done();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_priority();
        test_rr_order();
        test_mask();
        test_collision();
        test_watchdog();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Interrupt scheduler between the four hardware interrupt lines and the single CP0 exception entry in the datapath.
- Synchronises the raw lines, latches rising edges as pending requests, and masks them with a software-writable enable register.
- Arbitrates one winner at a time and presents it to CP0 as irq, irq_id and cause.
- Sequences each service episode: request, acknowledge (exception entry), then done (rfe), with a watchdog that recovers from a lost rfe.

Parameters:
- NSRC, 4: number of interrupt sources; 2..16.
- IDW, 2: width of irq_id; must equal ceil(log2(NSRC)).
- TMO_CYC, 1024: clock cycles allowed in SERVICE before forced recovery; ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- hwint  in  NSRC  raw interrupt lines; asynchronous to clk.
- en_we  in  1  write strobe for the enable register.
- en_wd  in  NSRC  enable write data; bit=1 enables the source.
- int_ack  in  1  one-cycle pulse: CPU has taken the exception entry.
- int_done  in  1  one-cycle pulse: CPU has executed rfe.
- irq  out  1  registered request to the CP0 exception path.
- irq_id  out  IDW  registered id of the granted source.
- cause  out  32  {16'b0, zero-extended pending[NSRC-1:0] in [15:8], 3'b0, tmo_err in [4], 2'b0, irq_id zero-extended in [1:0]}; NSRC ≤ 8 for full cause visibility.
- pending  out  NSRC  latched, not yet granted requests.
- busy  out  1  high in REQ or SERVICE.
- tmo_err  out  1  sticky; set when the SERVICE watchdog expires.

Behaviour:
- Reset (reset=0, async):
  - sync flops, edge flops, pending, irq, irq_id, counter and tmo_err cleared to 0.
  - enable = all ones; state = IDLE.
- Input synchronisation and edge capture:
  - Two-flop synchroniser per line, then rise = sync2 & ~sync2_d.
  - rise[i] sets pending[i] on the next edge.
- Latency: hwint first sampled high at edge k → pending[i]=1 after edge k+2 → irq=1 after edge k+3 (IDLE, enabled, no higher-priority competitor).
- Enable register:
  - en_we loads en_wd at the clock edge.
  - Only affects arbitration in IDLE; a grant already issued is never retracted.
- State machine (one-hot or binary; 3 states):
  - IDLE:
    - candidates = pending & enable.
    - If non-zero: latch winner into irq_id, assert irq, go REQ.
    - int_ack and int_done are ignored.
  - REQ:
    - irq and irq_id held stable.
    - On int_ack: clear pending[irq_id], drop irq, load counter = 0, go SERVICE.
    - int_done is ignored.
  - SERVICE:
    - counter increments each cycle.
    - On int_done: go IDLE.
    - If counter reaches TMO_CYC-1 without int_done: set tmo_err, go IDLE.
    - int_ack is ignored.
- Arbitration: fixed priority, lowest index wins (see Optional Feature for the alternative).
- Simultaneous events:
  - rise[i] in the same cycle that int_ack clears pending[i]: set wins, pending[i] stays 1.
  - int_done and the timeout in the same cycle: int_done wins, tmo_err is not set.
- Re-grant: the earliest irq re-assertion after int_done is one cycle later (IDLE evaluates, then REQ).
- tmo_err is cleared only by reset.
- Level-high lines do not re-request; a new rising edge is required.
- Reset mid-episode: returns to IDLE immediately; pending requests are lost.

Optional Feature:
- Macro: IRQ_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - A last_id register (reset 0) is updated on each int_ack.
  - Search starts at last_id+1 mod NSRC and wraps.
- Undefined: fixed priority, lowest index wins; no last_id register.

Test Plan:
- Single source: reset release; raise hwint=4'b0100 → irq=1, irq_id=2 three edges after first sample; pulse int_ack → irq=0, pending=0, busy=1; pulse int_done → busy=0 next edge.
- Priority: edges on lines 1 and 3 in the same cycle → irq_id=1.
  - After int_ack/int_done: irq_id=3, one cycle after int_done.
  - With IRQ_SCHED_RR_EN and last_id=1, edges on 0 and 3 → irq_id=3.
- Masking: en_we with en_wd=4'b1110, edge on line 0 → pending=4'b0001, irq stays 0; write 4'b1111 → irq=1, irq_id=0.
- Set/clear collision: hold in REQ on id 2, re-pulse line 2 so rise coincides with int_ack → pending[2] remains 1; after int_done, irq re-asserts with irq_id=2.
- Watchdog: TMO_CYC=8, ack with no int_done → after 8 SERVICE cycles tmo_err=1, state IDLE, cause[4]=1; a further pending request is granted normally.
- Async reset: drive reset=0 mid-SERVICE between clock edges → irq, busy and pending are 0 immediately without a clock edge; enable reads back as 4'b1111.
